// File: rtl/n64_vi_tx_pkg.sv
// n64adv_vi_pkg: VI timing constants, packet phases and colour-bar table.
// Pixel-stream fields are present when N64_VI_TX_EXTPIX_EN is defined.
package n64adv_vi_pkg;

  localparam logic [9:0] H_TOTAL_NTSC = 10'd773;
  localparam logic [9:0] H_TOTAL_PAL  = 10'd794;
  localparam logic [8:0] V_TOTAL_NTSC = 9'd263;
  localparam logic [8:0] V_TOTAL_PAL  = 9'd313;

  localparam logic [9:0] HSYNC_END = 10'd56;
  localparam logic [9:0] CLAMP_BEG = 10'd57;
  localparam logic [9:0] CLAMP_END = 10'd72;
  localparam logic [9:0] HACT_BEG  = 10'd108;
  localparam logic [9:0] HACT_END  = 10'd747;
  localparam logic [9:0] BAR_W     = 10'd80;

  localparam logic [8:0] VSYNC_LINES   = 9'd3;
  localparam logic [8:0] VACT_BEG_NTSC = 9'd18;
  localparam logic [8:0] VACT_END_NTSC = 9'd257;
  localparam logic [8:0] VACT_BEG_PAL  = 9'd23;
  localparam logic [8:0] VACT_END_PAL  = 9'd310;

  localparam logic [6:0] COMP_ON = 7'd127;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } phase_e;

  // {R,G,B} on/off; index 0 is the leftmost bar
  localparam logic [7:0][2:0] BAR_TBL = '{
    3'b000, 3'b001, 3'b100, 3'b101,
    3'b010, 3'b011, 3'b110, 3'b111
  };

  typedef struct packed {
    phase_e     ph;
    logic       nvsync;
    logic       nclamp;
    logic       nhsync;
    logic       ncsync;
    logic       act;
    logic       field;
`ifdef N64_VI_TX_EXTPIX_EN
    logic       pre_act;
`else
    logic [2:0] bar;
`endif
  } vi_tim_t;

endpackage

// File: rtl/n64_vi_tx_if.sv
// n64_vi_tx_if: VI output bus plus optional pixel-stream handshake.
// Pixel-stream signals exist only with N64_VI_TX_EXTPIX_EN.
interface n64_vi_tx_if;
  logic       nVDSYNC;
  logic [6:0] VD_o;
  logic       field_o;
`ifdef N64_VI_TX_EXTPIX_EN
  logic [20:0] PIX_i;
  logic        PIX_valid;
  logic        PIX_ready;
  logic        underrun_o;

  modport master (
    output nVDSYNC, VD_o, field_o,
    output PIX_ready, underrun_o,
    input  PIX_i, PIX_valid
  );
  modport slave (
    input  nVDSYNC, VD_o, field_o,
    input  PIX_ready, underrun_o,
    output PIX_i, PIX_valid
  );
`else
  modport master (output nVDSYNC, VD_o, field_o);
  modport slave  (input  nVDSYNC, VD_o, field_o);
`endif
endinterface

// File: rtl/n64_vi_timing.sv
// n64_vi_timing: packet phase, packet/line counters, field and sync flags.
// N64_VI_TX_EXTPIX_EN adds the pre-active-packet request flag.
module n64_vi_timing
  import n64adv_vi_pkg::*;
(
  input  logic    VCLK,
  input  logic    nVRST,
  input  logic    pal_i,
  input  logic    interlace_i,
  output vi_tim_t tim_o
);

  phase_e     ph_q, ph_d;
  logic [9:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic       field_q, field_d;
  logic       pal_q, pal_d;
  logic       il_q, il_d;

  logic       start, pal, il, fld;
  logic       vs_lo, vact, hact, nhs, nvs;
  logic [9:0] htot, hhalf;
  logic [8:0] vtot, vbeg, vend;
`ifdef N64_VI_TX_EXTPIX_EN
  logic [9:0] hnxt;
`else
  logic [9:0] hoff;
`endif

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      ph_q    <= PH_SYNC;
      h_q     <= '0;
      v_q     <= '0;
      field_q <= 1'b0;
      pal_q   <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      h_q     <= h_d;
      v_q     <= v_d;
      field_q <= field_d;
      pal_q   <= pal_d;
      il_q    <= il_d;
    end
  end

  always_comb begin
    // mode inputs are live only on the first cycle of a frame
    start = (ph_q == PH_SYNC) && (h_q == '0) && (v_q == '0);
    pal   = start ? pal_i : pal_q;
    il    = start ? interlace_i : il_q;
    fld   = il & field_q;
    htot  = pal ? H_TOTAL_PAL : H_TOTAL_NTSC;
    hhalf = htot >> 1;
    vtot  = (pal ? V_TOTAL_PAL : V_TOTAL_NTSC) - {8'd0, fld};
    vbeg  = pal ? VACT_BEG_PAL : VACT_BEG_NTSC;
    vend  = pal ? VACT_END_PAL : VACT_END_NTSC;

    ph_d    = ph_q;
    h_d     = h_q;
    v_d     = v_q;
    field_d = field_q;
    pal_d   = pal;
    il_d    = il;

    unique case (ph_q)
      PH_SYNC: ph_d = PH_R;
      PH_R:    ph_d = PH_G;
      PH_G:    ph_d = PH_B;
      PH_B: begin
        ph_d = PH_SYNC;
        if (h_q == htot - 10'd1) begin
          h_d = '0;
          if (v_q == vtot - 9'd1) begin
            v_d     = '0;
            field_d = il & ~fld;
          end else begin
            v_d = v_q + 9'd1;
          end
        end else begin
          h_d = h_q + 10'd1;
        end
      end
    endcase

    // odd field moves both vsync edges to mid-line
    if (fld)
      vs_lo = ((v_q == 9'd0) && (h_q >= hhalf)) ||
              (v_q == 9'd1) || (v_q == 9'd2) ||
              ((v_q == VSYNC_LINES) && (h_q < hhalf));
    else
      vs_lo = v_q < VSYNC_LINES;

    nvs  = ~vs_lo;
    nhs  = h_q > HSYNC_END;
    hact = (h_q >= HACT_BEG) && (h_q <= HACT_END);
    vact = (v_q >= vbeg) && (v_q <= vend);

    tim_o        = '0;
    tim_o.ph     = ph_q;
    tim_o.nvsync = nvs;
    tim_o.nhsync = nhs;
    tim_o.ncsync = ~(nhs ^ nvs);
    tim_o.nclamp = ~((h_q >= CLAMP_BEG) && (h_q <= CLAMP_END));
    tim_o.act    = hact & vact;
    tim_o.field  = fld;
`ifdef N64_VI_TX_EXTPIX_EN
    hnxt          = h_q + 10'd1;
    tim_o.pre_act = (ph_q == PH_B) && vact &&
                    (hnxt >= HACT_BEG) && (hnxt <= HACT_END);
`else
    hoff      = h_q - HACT_BEG;
    tim_o.bar = 3'(hoff / BAR_W);
`endif
  end

endmodule

// File: rtl/n64_vi_tx.sv
// n64_vi_tx: multiplexes sync/R/G/B into 4-phase VI packets, registered.
// N64_VI_TX_EXTPIX_EN replaces colour bars with an external pixel stream.
module n64_vi_tx
  import n64adv_vi_pkg::*;
(
  input  logic        VCLK,
  input  logic        nVRST,
  input  logic        pal_i,
  input  logic        interlace_i,
  n64_vi_tx_if.master vi
);

  vi_tim_t    tim;
  logic [6:0] r, g, b;
  logic [6:0] vd_q, vd_d;
  logic       nvds_q, nvds_d;
  logic       fld_q;

  n64_vi_timing u_tim (
    .VCLK        (VCLK),
    .nVRST       (nVRST),
    .pal_i       (pal_i),
    .interlace_i (interlace_i),
    .tim_o       (tim)
  );

`ifdef N64_VI_TX_EXTPIX_EN
  logic        rdy_q, und_q, ok_q;
  logic [20:0] pix_q;

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      rdy_q <= 1'b0;
      und_q <= 1'b0;
      ok_q  <= 1'b0;
      pix_q <= '0;
    end else begin
      rdy_q <= tim.pre_act;
      if (rdy_q) begin
        ok_q <= vi.PIX_valid;
        if (vi.PIX_valid) pix_q <= vi.PIX_i;
        else              und_q <= 1'b1;
      end
    end
  end

  always_comb begin
    {r, g, b} = (tim.act && ok_q) ? pix_q : 21'd0;
  end

  assign vi.PIX_ready  = rdy_q;
  assign vi.underrun_o = und_q;
`else
  logic [2:0] rgb;

  always_comb begin
    rgb = tim.act ? BAR_TBL[tim.bar] : 3'b000;
    r   = rgb[2] ? COMP_ON : 7'd0;
    g   = rgb[1] ? COMP_ON : 7'd0;
    b   = rgb[0] ? COMP_ON : 7'd0;
  end
`endif

  always_comb begin
    nvds_d = 1'b1;
    vd_d   = '0;
    unique case (tim.ph)
      PH_SYNC: begin
        nvds_d = 1'b0;
        vd_d   = {3'b000, tim.nvsync, tim.nclamp,
                  tim.nhsync, tim.ncsync};
      end
      PH_R: vd_d = r;
      PH_G: vd_d = g;
      PH_B: vd_d = b;
    endcase
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      vd_q   <= 7'h7F;
      nvds_q <= 1'b1;
      fld_q  <= 1'b0;
    end else begin
      vd_q   <= vd_d;
      nvds_q <= nvds_d;
      fld_q  <= tim.field;
    end
  end

  assign vi.nVDSYNC = nvds_q;
  assign vi.VD_o    = vd_q;
  assign vi.field_o = fld_q;

endmodule

// File: tb/tb_n64_vi_tx.sv
// tb_n64_vi_tx: random-mode VI stream checked against a frame-time model.
// Pixel-stream checks are compiled in with N64_VI_TX_EXTPIX_EN.
module tb_n64_vi_tx;

  logic VCLK = 1'b0;
  logic nVRST;
  logic pal_i;
  logic interlace_i;

  n64_vi_tx_if vi ();

  n64_vi_tx dut (
    .VCLK        (VCLK),
    .nVRST       (nVRST),
    .pal_i       (pal_i),
    .interlace_i (interlace_i),
    .vi          (vi)
  );

  always #5 VCLK = ~VCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  localparam bit [2:0] BARS [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010,
    3'b101, 3'b100, 3'b001, 3'b000
  };

  int         m_line, m_pkt, m_ph;
  bit         m_pal, m_il, m_fld;
  logic [6:0] e_vd;
  logic       e_nvds, e_fld;
  bit         chk_on;
  logic [9:0] jh;
  logic [8:0] jv;
`ifdef N64_VI_TX_EXTPIX_EN
  bit          e_rdy, e_und, m_ok;
  logic [20:0] m_pix;
`endif

  function automatic int ht();
    return m_pal ? 794 : 773;
  endfunction

  function automatic int vt();
    return (m_pal ? 313 : 263) - ((m_il && m_fld) ? 1 : 0);
  endfunction

  function automatic bit act(input int line, input int pkt);
    bit vis;
    vis = m_pal ? (line >= 23 && line <= 310)
                : (line >= 18 && line <= 257);
    return vis && pkt >= 108 && pkt <= 747;
  endfunction

  task automatic m_reset();
    m_line = 0; m_pkt = 0; m_ph = 0; m_fld = 0;
    e_vd = 7'h7F; e_nvds = 1'b1; e_fld = 1'b0;
`ifdef N64_VI_TX_EXTPIX_EN
    e_rdy = 0; e_und = 0; m_ok = 0; m_pix = '0;
`endif
  endtask

  // model position = time since frame start; outputs lag it by one VCLK
  task automatic m_step();
    int h, half, lin;
    bit nvs, nhs, ncl;
    logic [20:0] c;
`ifndef N64_VI_TX_EXTPIX_EN
    bit [2:0] b3;
`endif
    if (m_line == 0 && m_pkt == 0 && m_ph == 0) begin
      m_pal = pal_i;
      m_il  = interlace_i;
    end
    h    = ht();
    half = h / 2;
    lin  = m_line * h + m_pkt;
    if (m_il && m_fld) nvs = !(lin >= half && lin < 3 * h + half);
    else               nvs = !(lin < 3 * h);
    nhs = m_pkt >= 57;
    ncl = !(m_pkt >= 57 && m_pkt <= 72);
    c = '0;
    if (act(m_line, m_pkt)) begin
`ifdef N64_VI_TX_EXTPIX_EN
      if (m_ok) c = m_pix;
`else
      b3 = BARS[(m_pkt - 108) / 80];
      c  = {b3[2] ? 7'd127 : 7'd0,
            b3[1] ? 7'd127 : 7'd0,
            b3[0] ? 7'd127 : 7'd0};
`endif
    end
    case (m_ph)
      0:       e_vd = {3'b000, nvs, ncl, nhs, nhs == nvs};
      1:       e_vd = c[20:14];
      2:       e_vd = c[13:7];
      default: e_vd = c[6:0];
    endcase
    e_nvds = m_ph != 0;
    e_fld  = m_il && m_fld;
`ifdef N64_VI_TX_EXTPIX_EN
    if (e_rdy) begin
      m_ok = vi.PIX_valid;
      if (vi.PIX_valid) m_pix = vi.PIX_i;
      else              e_und = 1;
    end
    e_rdy = m_ph == 3 && act(m_line, m_pkt + 1);
`endif
    m_ph++;
    if (m_ph == 4) begin
      m_ph = 0;
      m_pkt++;
      if (m_pkt == h) begin
        m_pkt = 0;
        m_line++;
        if (m_line == vt()) begin
          m_line = 0;
          m_fld  = m_il ? !m_fld : 1'b0;
        end
      end
    end
  endtask

  always @(posedge VCLK) if (nVRST) m_step();

  always @(negedge VCLK) begin
    if (chk_on) begin
      chk("vd", 32'(vi.VD_o), 32'(e_vd));
      chk("nvdsync", 32'(vi.nVDSYNC), 32'(e_nvds));
      chk("field", 32'(vi.field_o), 32'(e_fld));
`ifdef N64_VI_TX_EXTPIX_EN
      chk("ready", 32'(vi.PIX_ready), 32'(e_rdy));
      chk("underrun", 32'(vi.underrun_o), 32'(e_und));
`endif
    end
  end

`ifdef N64_VI_TX_EXTPIX_EN
  always @(negedge VCLK) begin
    vi.PIX_i     = $urandom_range(0, 1) ? {7'd1, 7'd2, 7'd3}
                                        : 21'($urandom);
    vi.PIX_valid = $urandom_range(0, 15) != 0;
  end
`endif

  task automatic run(input int n);
    repeat (n) @(negedge VCLK);
  endtask

  // skip ahead in the frame by loading the packet/line counters
  task jump(input int line, input int pkt);
    while (m_ph == 3) @(negedge VCLK);
    jh = 10'(pkt);
    jv = 9'(line);
    force dut.u_tim.h_q = jh;
    force dut.u_tim.v_q = jv;
    m_pkt  = pkt;
    m_line = line;
    @(negedge VCLK);
    release dut.u_tim.h_q;
    release dut.u_tim.v_q;
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_vd"}, 32'(vi.VD_o), 32'h7F);
    chk({tag, "_nvds"}, 32'(vi.nVDSYNC), 32'd1);
    chk({tag, "_fld"}, 32'(vi.field_o), 32'd0);
  endtask

  initial begin
    bit found;
    nVRST = 1'b1;
    pal_i = 1'b0;
    interlace_i = 1'b0;
    chk_on = 0;
`ifdef N64_VI_TX_EXTPIX_EN
    vi.PIX_i = '0;
    vi.PIX_valid = 1'b0;
`endif
    m_reset();
    #1 nVRST = 1'b0;
    m_reset();
    chk_on = 1;
    #2 rst_check("rst");
    repeat (3) @(negedge VCLK);
    nVRST = 1'b1;
    @(negedge VCLK);
    chk("first_vd", 32'(vi.VD_o), 32'h05);
    chk("first_nvds", 32'(vi.nVDSYNC), 32'd0);

    run(2 * 3092 + $urandom_range(0, 500));
    jump(17, 700 + $urandom_range(0, 40));
    run(3 * 3092);

    jump(100, 10);
    pal_i = 1'b1;
    interlace_i = 1'b1;
    run(200);
    jump(262, 770);
    run(4 * 3176 + $urandom_range(0, 400));

    jump(22, 700);
    run(2 * 3176);
    pal_i = 1'b0;
    jump(312, 790);
    run(4 * 3092 + $urandom_range(0, 200));

    pal_i = 1'($urandom);
    interlace_i = 1'($urandom);
    jump(260, 770);
    run(4000);

    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge VCLK);
      found = (m_pkt == 300) && (m_ph == 1);
    end
    chk("wait_pkt300", 32'(found), 32'd1);
    #2 nVRST = 1'b0;
    m_reset();
    #1 rst_check("midrst");
    repeat (2) @(negedge VCLK);
    nVRST = 1'b1;
    @(negedge VCLK);
    chk("restart_vd", 32'(vi.VD_o), 32'h05);
    run(3100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
